tile_ram_arbiter: RTL and testbench
===================================

TILE_RAM_ARBITER -- requirements
Module: tile_ram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 4, tile address width (16 tiles); DATA_W, 8, tile word width ([7:2] pair id, [1] flipped, [0] cursor).
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge
- resetn  in  1  synchronous, active-low reset
- start_init  in  1  one-cycle pulse: begin board fill
- seed  in  4  shuffle seed, sampled on start_init
- busy  out  1  high while board fill runs
- init_done  out  1  one-cycle pulse after last fill write
- req_g  in  1  game requester request, held until granted
- we_g  in  1  game write enable, qualifies req_g
- addr_g  in  ADDR_W  game address
- wdata_g  in  DATA_W  game write data
- gnt_g  out  1  game grant pulse
- rvalid_g  out  1  game read data valid
- req_d  in  1  display requester read request, held until granted
- addr_d  in  ADDR_W  display address
- gnt_d  out  1  display grant pulse
- rvalid_d  out  1  display read data valid
- rdata  out  DATA_W  read data returned to either requester
- ram_addr  out  ADDR_W  single-port RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, one cycle after address

Function
REQ-003 The block SHALL own the single RAM port; exactly one of {fill, game, display} SHALL drive it per cycle.
REQ-004 States SHALL be IDLE, FILL; reset enters IDLE.
REQ-005 IDLE + start_init SHALL enter FILL next cycle; busy=1 from that cycle until init_done.
REQ-006 FILL SHALL write addresses 0..15 in order, one per cycle, ram_we=1; word = {(a ^ seed_q) >> 1, 1'b0, (a==0)}; 16 cycles total.
REQ-007 The cycle after writing address 15: init_done=1 for one cycle, busy=0, return to IDLE.
REQ-008 start_init during FILL SHALL be ignored; seed_q SHALL hold.
REQ-009 During FILL, req_g/req_d SHALL not be granted; requests remain pending.
REQ-010 IDLE arbitration: single requester granted immediately; both requesting -> round-robin, the requester not granted last wins; after reset, game has priority.
REQ-011 Grant cycle: gnt_x=1, ram_addr=addr_x; game write: ram_we=1, ram_wdata=wdata_g, no rvalid.
REQ-012 Read grant SHALL produce rvalid_x=1 and rdata=ram_rdata exactly one cycle after gnt_x (latency 1).
REQ-013 Back-to-back grants SHALL be allowed every cycle; throughput one access/cycle.
REQ-014 start_init and a request in the same IDLE cycle: the request is granted that cycle; FILL starts next cycle.
REQ-015 A read granted in the last IDLE cycle SHALL still return its rvalid during the first FILL cycle.
REQ-016 ram_we SHALL be 0 whenever no write is granted; ram_addr/ram_wdata don't-care then.

Reset
REQ-017 resetn=0 at a clock edge SHALL force IDLE, busy=0, init_done=0, gnt_g=gnt_d=0, rvalid_g=rvalid_d=0, ram_we=0, rdata=0, seed_q=0, round-robin pointer=game.
REQ-018 Reset mid-FILL SHALL abort the fill without further writes; board content is undefined until next start_init.

Configuration
REQ-019 Macro TILE_ARB_SHUFFLE_EN: defined -> fill uses seed_q as in REQ-006; undefined -> seed port ignored, seed_q fixed 0 (ordered pairs 0,0,1,1,...,7,7).

Structure
REQ-020 Shared package SHALL hold: ADDR_W/DATA_W defaults, tile bit-field positions (PAIR_MSB=7, PAIR_LSB=2, FLIP_BIT=1, CURSOR_BIT=0), state encoding, NUM_TILES=16.
REQ-021 One sub-module, tile_rr_arbiter (2-way round-robin, pointer register), is natural; fill sequencer stays in the top.

Verification
REQ-022 Scenarios:
- Reset, start_init with seed=4'h5 (SHUFFLE_EN) -> 16 writes; addr 0 word 8'h09, addr 5 word 8'h00; init_done at cycle 17; each pair id exactly twice.
- Same without TILE_ARB_SHUFFLE_EN -> addr 0 = 8'h01, addr 15 = 8'h1C.
- req_g and req_d held together 4 cycles -> grants alternate g,d,g,d; each read's rvalid exactly 1 cycle later with correct rdata.
- req_d asserted during FILL at cycle 3 -> no gnt_d until the cycle after init_done, then granted.
- Game write addr 4'h6 data 8'hA6, then display read addr 6 -> rdata 8'hA6, rvalid_d only.
- resetn low at fill cycle 8 -> no further ram_we, busy=0 next cycle, all outputs at reset values.

Source files
------------

// File: rtl/tile_ram_arbiter_pkg.sv
// Shared definitions for the tile RAM arbiter: default widths, tile word
// bit-fields and the fill FSM state encoding.
package tile_ram_arbiter_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int NUM_TILES  = 16;
    localparam int SEED_W     = 4;

    localparam int PAIR_MSB   = 7;
    localparam int PAIR_LSB   = 2;
    localparam int FLIP_BIT   = 1;
    localparam int CURSOR_BIT = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

endpackage

// File: rtl/tile_rr_arbiter.sv
// Two-way round-robin arbiter between the game and display requesters;
// the requester not granted last wins a tie, game first after reset.
module tile_rr_arbiter (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic req_g,
    input  logic req_d,
    output logic gnt_g,
    output logic gnt_d
);

    logic prio_d;

    always_comb begin
        gnt_g = 1'b0;
        gnt_d = 1'b0;
        if (en) begin
            if (req_g && (!req_d || !prio_d)) begin
                gnt_g = 1'b1;
            end else if (req_d) begin
                gnt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prio_d <= 1'b0;
        end else if (gnt_g) begin
            prio_d <= 1'b1;
        end else if (gnt_d) begin
            prio_d <= 1'b0;
        end
    end

endmodule

// File: rtl/tile_ram_arbiter.sv
// Owns the single tile RAM port: board fill sequencer plus game/display
// arbitration. Define TILE_ARB_SHUFFLE_EN to let the seed port shuffle the fill.
module tile_ram_arbiter
    import tile_ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_init,
    input  logic [3:0]        seed,
    output logic              busy,
    output logic              init_done,
    input  logic              req_g,
    input  logic              we_g,
    input  logic [ADDR_W-1:0] addr_g,
    input  logic [DATA_W-1:0] wdata_g,
    output logic              gnt_g,
    output logic              rvalid_g,
    input  logic              req_d,
    input  logic [ADDR_W-1:0] addr_d,
    output logic              gnt_d,
    output logic              rvalid_d,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q;
    logic [SEED_W-1:0]   seed_q;
    logic [SEED_W-1:0]   seed_next;
    logic                init_done_q;
    logic                rd_g_q, rd_d_q;
    logic                fill_last;
    logic                arb_en;
    logic [ADDR_W-1:0]   mix;
    logic [DATA_W-1:0]   fill_word;

`ifdef TILE_ARB_SHUFFLE_EN
    assign seed_next = seed;
`else
    logic unused_seed;
    assign unused_seed = ^seed;
    assign seed_next   = '0;
`endif

    assign fill_last = (state_q == ST_FILL) && (cnt_q == ADDR_W'(NUM_TILES - 1));
    // The init_done cycle is kept free of grants so requests held over the
    // fill are served from the following cycle.
    assign arb_en    = (state_q == ST_IDLE) && !init_done_q;

    tile_rr_arbiter u_arb (
        .clk    (clk),
        .resetn (resetn),
        .en     (arb_en),
        .req_g  (req_g),
        .req_d  (req_d),
        .gnt_g  (gnt_g),
        .gnt_d  (gnt_d)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_init) state_d = ST_FILL;
            ST_FILL: if (fill_last)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        mix       = cnt_q ^ ADDR_W'(seed_q);
        fill_word = '0;
        fill_word[PAIR_MSB:PAIR_LSB] = (PAIR_MSB - PAIR_LSB + 1)'(mix >> 1);
        fill_word[FLIP_BIT]          = 1'b0;
        fill_word[CURSOR_BIT]        = (cnt_q == '0);
    end

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (state_q == ST_FILL) begin
            ram_addr  = cnt_q;
            ram_we    = 1'b1;
            ram_wdata = fill_word;
        end else if (gnt_g) begin
            ram_addr  = addr_g;
            ram_we    = we_g;
            ram_wdata = wdata_g;
        end else if (gnt_d) begin
            ram_addr  = addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q       <= '0;
            seed_q      <= '0;
            init_done_q <= 1'b0;
            rd_g_q      <= 1'b0;
            rd_d_q      <= 1'b0;
        end else begin
            init_done_q <= fill_last;
            rd_g_q      <= gnt_g && !we_g;
            rd_d_q      <= gnt_d;
            if ((state_q == ST_IDLE) && start_init) begin
                cnt_q  <= '0;
                seed_q <= seed_next;
            end else if (state_q == ST_FILL) begin
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

    assign busy      = (state_q == ST_FILL);
    assign init_done = init_done_q;
    assign rvalid_g  = rd_g_q;
    assign rvalid_d  = rd_d_q;
    assign rdata     = (rd_g_q || rd_d_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_tile_ram_arbiter.sv
// Self-checking bench for tile_ram_arbiter with a behavioural RAM and a read
// scoreboard; honours TILE_ARB_SHUFFLE_EN for the expected fill contents.
module tb_tile_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
`ifdef TILE_ARB_SHUFFLE_EN
    localparam logic [3:0] FILL_SEED = 4'h5;
`else
    localparam logic [3:0] FILL_SEED = 4'h0;
`endif

    logic          clk = 1'b0;
    logic          resetn, start_init;
    logic [3:0]    seed;
    logic          busy, init_done;
    logic          req_g, we_g, gnt_g, rvalid_g;
    logic [AW-1:0] addr_g;
    logic [DW-1:0] wdata_g;
    logic          req_d, gnt_d, rvalid_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    tile_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .resetn(resetn), .start_init(start_init), .seed(seed),
        .busy(busy), .init_done(init_done),
        .req_g(req_g), .we_g(we_g), .addr_g(addr_g), .wdata_g(wdata_g),
        .gnt_g(gnt_g), .rvalid_g(rvalid_g),
        .req_d(req_d), .addr_d(addr_d), .gnt_d(gnt_d), .rvalid_d(rvalid_d),
        .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] fill_exp(input int a, input logic [3:0] s);
        logic [3:0] m;
        m = 4'(a) ^ s;
        return {3'b000, m[3:1], 1'b0, (a == 0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read scoreboard: expected data pushed at grant, popped at rvalid.
    logic [7:0] ref_mem [16];
    logic [7:0] qg[$];
    logic [7:0] qd[$];
    logic       exp_rv_g = 1'b0;
    logic       exp_rv_d = 1'b0;
    logic       mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("rvalid_g_timing", rvalid_g, exp_rv_g);
            check("rvalid_d_timing", rvalid_d, exp_rv_d);
            if (rvalid_g) begin
                if (qg.size() == 0) check("rvalid_g_unexpected", 1, 0);
                else check("rdata_g", rdata, qg.pop_front());
            end
            if (rvalid_d) begin
                if (qd.size() == 0) check("rvalid_d_unexpected", 1, 0);
                else check("rdata_d", rdata, qd.pop_front());
            end
            exp_rv_g = gnt_g && !we_g;
            exp_rv_d = gnt_d;
            if (gnt_g && !we_g) qg.push_back(ref_mem[addr_g]);
            if (gnt_d)          qd.push_back(ref_mem[addr_d]);
            if (gnt_g && we_g)  ref_mem[addr_g] = wdata_g;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         pair_cnt [64];
    logic [7:0] w0, w5, w15;

    initial begin
        resetn = 1'b0; start_init = 1'b0; seed = '0;
        req_g = 1'b0; we_g = 1'b0; addr_g = '0; wdata_g = '0;
        req_d = 1'b0; addr_d = '0;
        foreach (pair_cnt[p]) pair_cnt[p] = 0;
        w0 = '0; w5 = '0; w15 = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_init_done", init_done, 0);
        check("rst_gnt", {gnt_g, gnt_d}, 0);
        check("rst_rvalid", {rvalid_g, rvalid_d}, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_rdata", rdata, 0);
        tick();
        resetn = 1'b1;
        mon_en = 1'b1;

        // Board fill; display request arrives at fill cycle 3, stray start at cycle 5
        seed = 4'h5; start_init = 1'b1;
        @(negedge clk);
        check("start_busy", busy, 0);
        check("start_ram_we", ram_we, 0);
        tick();
        start_init = 1'b0; seed = '0;
        for (int i = 0; i < 16; i++) begin
            if (i == 2) begin req_d = 1'b1; addr_d = 4'd5; end
            if (i == 4) begin start_init = 1'b1; seed = 4'hA; end
            if (i == 5) begin start_init = 1'b0; seed = '0; end
            @(negedge clk);
            check("fill_busy", busy, 1);
            check("fill_we", ram_we, 1);
            check("fill_addr", ram_addr, i);
            check("fill_word", ram_wdata, fill_exp(i, FILL_SEED));
            check("fill_no_gnt", {gnt_g, gnt_d}, 0);
            check("fill_no_done", init_done, 0);
            pair_cnt[ram_wdata[7:2]]++;
            if (i == 0)  w0  = ram_wdata;
            if (i == 5)  w5  = ram_wdata;
            if (i == 15) w15 = ram_wdata;
            ref_mem[i] = fill_exp(i, FILL_SEED);
            tick();
        end
        @(negedge clk);
        check("done_pulse", init_done, 1);
        check("done_busy", busy, 0);
        check("done_no_gnt_d", gnt_d, 0);
        check("done_ram_we", ram_we, 0);
`ifdef TILE_ARB_SHUFFLE_EN
        check("word_addr0", w0, 8'h09);
        check("word_addr5", w5, 8'h00);
`else
        check("word_addr0", w0, 8'h01);
        check("word_addr15", w15, 8'h1C);
`endif
        for (int p = 0; p < 8; p++) check("pair_twice", pair_cnt[p], 2);
        tick();
        @(negedge clk);
        check("done_one_cycle", init_done, 0);
        check("pending_gnt_d", gnt_d, 1);
        check("pending_addr", ram_addr, 5);
        tick();
        req_d = 1'b0;

        // Both requesters held: alternation g,d,g,d
        req_g = 1'b1; we_g = 1'b0; req_d = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr_g = 4'(k); addr_d = 4'(8 + k);
            @(negedge clk);
            check("rr_gnt_g", gnt_g, (k % 2) == 0);
            check("rr_gnt_d", gnt_d, (k % 2) == 1);
            check("rr_addr", ram_addr, (k % 2) == 0 ? k : 8 + k);
            tick();
        end
        req_g = 1'b0; req_d = 1'b0;
        @(negedge clk);
        check("idle_ram_we", ram_we, 0);
        tick();

        // Game write then display read of the same tile
        req_g = 1'b1; we_g = 1'b1; addr_g = 4'h6; wdata_g = 8'hA6;
        @(negedge clk);
        check("wr_gnt_g", gnt_g, 1);
        check("wr_ram_we", ram_we, 1);
        check("wr_ram_addr", ram_addr, 6);
        check("wr_ram_wdata", ram_wdata, 8'hA6);
        tick();
        req_g = 1'b0; we_g = 1'b0;
        req_d = 1'b1; addr_d = 4'h6;
        @(negedge clk);
        check("rd_gnt_d", gnt_d, 1);
        check("rd_ram_we", ram_we, 0);
        check("wr_no_rvalid_g", rvalid_g, 0);
        tick();
        req_d = 1'b0;
        @(negedge clk);
        check("rd_rvalid_d", rvalid_d, 1);
        check("rd_data_a6", rdata, 8'hA6);
        tick();

        // Request and start_init together, then reset in the middle of the fill
        req_g = 1'b1; we_g = 1'b0; addr_g = 4'h3; start_init = 1'b1; seed = 4'h0;
        @(negedge clk);
        check("mix_gnt_g", gnt_g, 1);
        check("mix_busy", busy, 0);
        tick();
        req_g = 1'b0; start_init = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge clk);
            if (j == 1) begin
                check("mix_busy_fill", busy, 1);
                check("mix_rvalid_g", rvalid_g, 1);
            end
            check("abort_fill_addr", ram_addr, j - 1);
            if (j < 8) tick();
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        @(negedge clk);
        check("abort_ram_we", ram_we, 0);
        check("abort_busy", busy, 0);
        check("abort_init_done", init_done, 0);
        check("abort_gnt", {gnt_g, gnt_d}, 0);
        check("abort_rvalid", {rvalid_g, rvalid_d}, 0);
        check("abort_rdata", rdata, 0);
        for (int n = 0; n < 3; n++) begin
            tick();
            @(negedge clk);
            check("abort_no_write", ram_we, 0);
            check("abort_stays_idle", busy, 0);
        end
        tick();

        // Round-robin pointer back to game after reset
        req_g = 1'b1; we_g = 1'b1; addr_g = 4'h9; wdata_g = 8'h33;
        req_d = 1'b1; addr_d = 4'h9;
        @(negedge clk);
        check("post_rst_gnt_g", gnt_g, 1);
        check("post_rst_gnt_d", gnt_d, 0);
        tick();
        req_g = 1'b0; we_g = 1'b0;
        @(negedge clk);
        check("post_rst_then_d", gnt_d, 1);
        tick();
        req_d = 1'b0;
        @(negedge clk);
        check("post_rst_rdata", rdata, 8'h33);
        repeat (2) tick();

        check("queue_g_drained", qg.size(), 0);
        check("queue_d_drained", qd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
